keypad_emulator: RTL and testbench
==================================

// Module: keypad_emulator
// PURPOSE
//   Synthesizable 4x4 hex-keypad model: the responder side of the keypad scan interface.
//   It watches the scanner's active-low row drive and pulls the matching column low while
//   a commanded key is "pressed", with optional contact bounce on press and release.
//   It sits in benches and on-board self-test in place of the physical keypad, driving cols into the scanner.
// PARAMETERS
//   BOUNCE_CYCLES  16     length of each bounce window (press and release), in clk cycles
//   LFSR_SEED      8'hA5  initial LFSR state; 8'h00 is replaced by 8'h01
// PORTS
//   clk          in   1   system clock; all state updates on posedge
//   reset        in   1   asynchronous, active-low reset
//   rows         in   4   scanner row drive, active-low (row r selected when rows[r]==0)
//   press_req    in   1   request a press/hold/release cycle; accepted only when busy==0
//   key          in   4   hex key to press; sampled on acceptance
//   hold_cycles  in   16  clean-contact hold time; sampled on acceptance; 0 is treated as 1
//   cols         out  4   column lines to scanner, active-low, idle 4'b1111
//   busy         out  1   high from the cycle after acceptance until return to IDLE
//   done         out  1   one-cycle pulse on the cycle the FSM enters IDLE after RELEASE
// BEHAVIOUR
//   - Key map (row,col): r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E 0 F D.
//   - cols is combinational, with zero latency from rows:
//     cols = 4'b1111, except cols[c_k] = 0 when contact==1 and rows[r_k]==0.
//   - Only the latched key affects cols. Other rows low, or several rows low at once, have no effect.
//   - Reset (asynchronous, any state): state=IDLE, contact=0, busy=0, done=0, counters=0, LFSR=seed.
//     cols=4'b1111 during and after reset. Reset mid-press produces no done pulse.
//   - FSM: IDLE -> PRESS_B -> HOLD -> RELEASE_B -> IDLE.
//     IDLE: contact=0. On press_req==1, latch key and hold_cycles, then go to PRESS_B.
//     PRESS_B: lasts BOUNCE_CYCLES cycles. Each cycle contact=LFSR[0] and the LFSR steps.
//     HOLD: contact=1 for exactly max(hold_cycles,1) cycles.
//     RELEASE_B: same as PRESS_B, using a fresh count. On exit, contact=0, go to IDLE, done=1 for 1 cycle.
//   - LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It steps only in bounce states.
//   - busy rises the cycle after acceptance. press_req while busy==1 is ignored, not queued.
//   - Back-to-back: press_req high in the done cycle is accepted, because the FSM is already in IDLE.
//   - Counters are 16-bit and saturate, with no wrap. A bounce count of 0 means that state is skipped.
// CONFIGURATION
//   KEYPAD_BOUNCE_EN defined:   bounce windows behave as above.
//   KEYPAD_BOUNCE_EN undefined: PRESS_B and RELEASE_B are removed and the LFSR is not instantiated.
//     Sequence is IDLE -> HOLD (contact=1 immediately) -> IDLE, for a clean press.
//     BOUNCE_CYCLES is ignored. Other timing and busy/done rules are unchanged.
// TESTING
//   1. Reset low for 3 cycles with rows=4'b0000 -> cols=4'b1111, busy=0, done=0.
//      Release reset -> cols stays 4'b1111.
//   2. Bounce off: key=4'h5, hold_cycles=10, press_req 1 cycle, rows=4'b1101 -> cols=4'b1101 for 10 cycles.
//      Then cols=4'b1111 and one done pulse. busy was high for exactly 10 cycles.
//   3. Same press with rows cycling 1110/1101/1011/0111 -> cols goes low (4'b1101) only while rows==4'b1101.
//      Repeat for key=4'hD: cols=4'b0111 only while rows==4'b0111.
//   4. Bounce on, BOUNCE_CYCLES=16, key=4'h0, hold=20, rows=4'b0111 ->
//      16 cycles with cols[1] following the LFSR[0] reference model, 20 cycles of cols=4'b1101,
//      16 bounce cycles, then done. Total busy = 52 cycles.
//   5. Second press_req with key=4'h1 during HOLD -> ignored, the latched key stays 0.
//      press_req held high through done -> new press accepted immediately.
//   6. Reset asserted during HOLD -> cols=4'b1111 asynchronously, busy=0, no done.
//      Then hold_cycles=0 -> exactly 1 hold cycle.

Source files
------------

// File: rtl/keypad_emulator.sv
// ============================================================================
// Module  : keypad_emulator
// Purpose : Responder side of a 4x4 hex-keypad scan interface. Watches the
//           scanner's active-low row drive and pulls the column of the
//           commanded key low while that key is "pressed". Optional contact
//           bounce on press and release (LFSR driven).
// Config  : define KEYPAD_BOUNCE_EN to include the press/release bounce
//           windows and the LFSR; undefined gives a clean IDLE->HOLD->IDLE.
// Ports   : clk         - system clock, posedge
//           reset       - asynchronous, active-low reset
//           rows[3:0]   - scanner row drive, active-low
//           press_req   - start a press cycle (accepted only when idle)
//           key[3:0]    - hex key, sampled on acceptance
//           hold_cycles - clean-contact hold length, 0 treated as 1
//           cols[3:0]   - column lines to scanner, active-low, idle 4'b1111
//           busy        - high while a press cycle is in progress
//           done        - one-cycle pulse when the cycle returns to idle
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_emulator #(
  parameter logic [15:0] BOUNCE_CYCLES = 16'd16,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rows,
  input  logic        press_req,
  input  logic [3:0]  key,
  input  logic [15:0] hold_cycles,
  output logic [3:0]  cols,
  output logic        busy,
  output logic        done
);

`ifdef KEYPAD_BOUNCE_EN
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_B   = 2'd1,
    HOLD      = 2'd2,
    RELEASE_B = 2'd3
  } state_t;
`else
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;
`endif

  state_t      state;
  state_t      next_state;
  logic [3:0]  key_q;
  logic [15:0] hold_len;
  logic [15:0] cnt;
  logic        cnt_clr;
  logic        accept;
  logic        finish;
  logic        contact;
  logic        done_q;
  logic [1:0]  row_k;
  logic [1:0]  col_k;

`ifdef KEYPAD_BOUNCE_EN
  // A zero-length bounce window means the bounce states are skipped entirely.
  localparam logic        BOUNCE_SKIP = (BOUNCE_CYCLES == 16'd0);
  localparam logic [15:0] BOUNCE_LAST = BOUNCE_CYCLES - 16'd1;
  // An all-zero seed would lock the LFSR, so substitute 1.
  localparam logic [7:0]  SEED        = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  logic [7:0] lfsr;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; advances only while bouncing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= SEED;
    end else if (state == PRESS_B || state == RELEASE_B) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{BOUNCE_CYCLES, LFSR_SEED};
`endif

  // Key map: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E 0 F D
  always_comb begin
    row_k = 2'd0;
    col_k = 2'd0;
    case (key_q)
      4'h1: begin row_k = 2'd0; col_k = 2'd0; end
      4'h2: begin row_k = 2'd0; col_k = 2'd1; end
      4'h3: begin row_k = 2'd0; col_k = 2'd2; end
      4'hA: begin row_k = 2'd0; col_k = 2'd3; end
      4'h4: begin row_k = 2'd1; col_k = 2'd0; end
      4'h5: begin row_k = 2'd1; col_k = 2'd1; end
      4'h6: begin row_k = 2'd1; col_k = 2'd2; end
      4'hB: begin row_k = 2'd1; col_k = 2'd3; end
      4'h7: begin row_k = 2'd2; col_k = 2'd0; end
      4'h8: begin row_k = 2'd2; col_k = 2'd1; end
      4'h9: begin row_k = 2'd2; col_k = 2'd2; end
      4'hC: begin row_k = 2'd2; col_k = 2'd3; end
      4'hE: begin row_k = 2'd3; col_k = 2'd0; end
      4'h0: begin row_k = 2'd3; col_k = 2'd1; end
      4'hF: begin row_k = 2'd3; col_k = 2'd2; end
      default: begin row_k = 2'd3; col_k = 2'd3; end // 4'hD
    endcase
  end

  // Next-state and contact decode. cnt counts cycles spent in the current
  // state; cnt_clr restarts it on every state change.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    cnt_clr    = 1'b0;
    finish     = 1'b0;
    contact    = 1'b0;
    case (state)
      IDLE: begin
        if (press_req) begin
          accept  = 1'b1;
          cnt_clr = 1'b1;
`ifdef KEYPAD_BOUNCE_EN
          next_state = BOUNCE_SKIP ? HOLD : PRESS_B;
`else
          next_state = HOLD;
`endif
        end
      end
`ifdef KEYPAD_BOUNCE_EN
      PRESS_B: begin
        contact = lfsr[0];
        if (cnt == BOUNCE_LAST) begin
          cnt_clr    = 1'b1;
          next_state = HOLD;
        end
      end
      RELEASE_B: begin
        contact = lfsr[0];
        if (cnt == BOUNCE_LAST) begin
          cnt_clr    = 1'b1;
          finish     = 1'b1;
          next_state = IDLE;
        end
      end
`endif
      HOLD: begin
        contact = 1'b1;
        if (cnt == hold_len - 16'd1) begin
          cnt_clr = 1'b1;
`ifdef KEYPAD_BOUNCE_EN
          if (BOUNCE_SKIP) begin
            finish     = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = RELEASE_B;
          end
`else
          finish     = 1'b1;
          next_state = IDLE;
`endif
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 16'd0;
      key_q    <= 4'h0;
      hold_len <= 16'd0;
      done_q   <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= finish;
      if (accept) begin
        key_q    <= key;
        hold_len <= (hold_cycles == 16'd0) ? 16'd1 : hold_cycles;
      end
      // Saturating counter, held at zero while idle.
      if (cnt_clr || state == IDLE) begin
        cnt <= 16'd0;
      end else if (cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  // Zero-latency column response: only the latched key's row matters.
  always_comb begin
    cols = 4'b1111;
    if (contact && !rows[row_k]) begin
      cols[col_k] = 1'b0;
    end
  end

  assign busy = (state != IDLE);
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_emulator.sv
// ============================================================================
// Module  : tb_keypad_emulator
// Purpose : Self-checking bench for keypad_emulator. Table of key/row/column
//           vectors plus directed sequences for timing, ignore-while-busy,
//           back-to-back, reset-mid-press and (with KEYPAD_BOUNCE_EN) the
//           bounce windows against an LFSR reference.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_emulator;

`ifdef KEYPAD_BOUNCE_EN
  localparam int BW = 16;
`else
  localparam int BW = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rows;
  logic        press_req;
  logic [3:0]  key;
  logic [15:0] hold_cycles;
  logic [3:0]  cols;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  keypad_emulator #(
    .BOUNCE_CYCLES(16'd16),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rows       (rows),
    .press_req  (press_req),
    .key        (key),
    .hold_cycles(hold_cycles),
    .cols       (cols),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] k;
    logic [3:0] r;
    logic [3:0] c;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle request and advance to the first HOLD cycle.
  task automatic start_press(input logic [3:0] k, input logic [15:0] h);
    key         = k;
    hold_cycles = h;
    press_req   = 1'b1;
    tick();
    press_req   = 1'b0;
    repeat (BW) tick();
  endtask

  // Advance until done is seen (bounded); leaves time in the done cycle.
  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    chk(name, {15'd0, seen}, 16'd1);
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  initial begin
    logic [3:0] pat [4];
    logic [7:0] m;

    vecs[0]  = '{4'h5, 4'b1101, 4'b1101};
    vecs[1]  = '{4'h5, 4'b1110, 4'b1111};
    vecs[2]  = '{4'h5, 4'b1011, 4'b1111};
    vecs[3]  = '{4'h5, 4'b0000, 4'b1101};
    vecs[4]  = '{4'h5, 4'b1111, 4'b1111};
    vecs[5]  = '{4'hD, 4'b0111, 4'b0111};
    vecs[6]  = '{4'hD, 4'b1101, 4'b1111};
    vecs[7]  = '{4'h1, 4'b1110, 4'b1110};
    vecs[8]  = '{4'hA, 4'b1110, 4'b0111};
    vecs[9]  = '{4'h7, 4'b1011, 4'b1110};
    vecs[10] = '{4'hC, 4'b1011, 4'b0111};
    vecs[11] = '{4'hE, 4'b0111, 4'b1110};
    vecs[12] = '{4'hF, 4'b0111, 4'b1011};
    vecs[13] = '{4'h0, 4'b0111, 4'b1101};
    vecs[14] = '{4'h9, 4'b1011, 4'b1011};
    vecs[15] = '{4'h3, 4'b1110, 4'b1011};
    vecs[16] = '{4'h8, 4'b1011, 4'b1101};
    vecs[17] = '{4'hB, 4'b1101, 4'b0111};

    pat[0] = 4'b1110;
    pat[1] = 4'b1101;
    pat[2] = 4'b1011;
    pat[3] = 4'b0111;

    // Reset with all rows selected.
    reset = 1'b0; rows = 4'b0000; press_req = 1'b0; key = 4'h0; hold_cycles = 16'd0;
    repeat (3) tick();
    chk("reset_cols", {12'd0, cols}, 16'h000F);
    chk("reset_busy", {15'd0, busy}, 16'd0);
    chk("reset_done", {15'd0, done}, 16'd0);
    reset = 1'b1;
    tick();
    chk("post_reset_cols", {12'd0, cols}, 16'h000F);

    // Key 5, hold 10, row 1 selected: exactly 10 contact cycles, then done.
    rows = 4'b1101;
    start_press(4'h5, 16'd10);
    for (int i = 0; i < 10; i++) begin
      chk("hold_cols", {12'd0, cols}, 16'h000D);
      chk("hold_busy", {15'd0, busy}, 16'd1);
      chk("hold_done", {15'd0, done}, 16'd0);
      tick();
    end
    repeat (BW) tick();
    chk("end_done", {15'd0, done}, 16'd1);
    chk("end_busy", {15'd0, busy}, 16'd0);
    chk("end_cols", {12'd0, cols}, 16'h000F);
    tick();
    chk("done_pulse_width", {15'd0, done}, 16'd0);

    // Rows scanned while holding: only the key's own row pulls a column.
    start_press(4'h5, 16'd12);
    for (int i = 0; i < 12; i++) begin
      rows = pat[i % 4];
      #1;
      chk("scan5_cols", {12'd0, cols}, (rows == 4'b1101) ? 16'h000D : 16'h000F);
      tick();
    end
    wait_done("scan5_done");
    tick();
    start_press(4'hD, 16'd12);
    for (int i = 0; i < 12; i++) begin
      rows = pat[i % 4];
      #1;
      chk("scanD_cols", {12'd0, cols}, (rows == 4'b0111) ? 16'h0007 : 16'h000F);
      tick();
    end
    wait_done("scanD_done");
    tick();

    // Key map table.
    for (int v = 0; v < 18; v++) begin
      start_press(vecs[v].k, 16'd4);
      rows = vecs[v].r;
      #1;
      chk($sformatf("map_k%h_r%b", vecs[v].k, vecs[v].r), {12'd0, cols}, {12'd0, vecs[v].c});
      wait_done("map_done");
      tick();
    end

    // Request during HOLD is ignored; request held through done is accepted.
    rows = 4'b0111;
    start_press(4'h0, 16'd20);
    tick(); tick();
    key = 4'h1; press_req = 1'b1;
    tick();
    press_req = 1'b0;
    chk("busy_ignore_cols", {12'd0, cols}, 16'h000D);
    rows = 4'b1110;
    #1;
    chk("busy_ignore_key1", {12'd0, cols}, 16'h000F);
    rows = 4'b0111;
    key = 4'h5; hold_cycles = 16'd2; press_req = 1'b1;
    wait_done("b2b_first_done");
    tick();
    chk("b2b_accept_busy", {15'd0, busy}, 16'd1);
    press_req = 1'b0;
    repeat (BW) tick();
    rows = 4'b1101;
    #1;
    chk("b2b_key5_cols", {12'd0, cols}, 16'h000D);
    tick();
    chk("b2b_hold2_cols", {12'd0, cols}, 16'h000D);
    wait_done("b2b_second_done");
    tick();

    // Reset during HOLD: immediate idle, no done.
    rows = 4'b0111;
    start_press(4'h0, 16'd20);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("midreset_cols", {12'd0, cols}, 16'h000F);
    chk("midreset_busy", {15'd0, busy}, 16'd0);
    tick();
    chk("midreset_done", {15'd0, done}, 16'd0);
    reset = 1'b1;
    tick();
    chk("after_reset_done", {15'd0, done}, 16'd0);
    chk("after_reset_busy", {15'd0, busy}, 16'd0);

    // hold_cycles = 0 behaves as a single hold cycle.
    start_press(4'h0, 16'd0);
    chk("hold0_cols", {12'd0, cols}, 16'h000D);
    chk("hold0_busy", {15'd0, busy}, 16'd1);
    tick();
    repeat (BW) tick();
    chk("hold0_done", {15'd0, done}, 16'd1);
    chk("hold0_idle", {15'd0, busy}, 16'd0);
    tick();

`ifdef KEYPAD_BOUNCE_EN
    // Bounce windows follow the LFSR reference from a fresh seed.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    m = 8'hA5;
    rows = 4'b0111; key = 4'h0; hold_cycles = 16'd20; press_req = 1'b1;
    tick();
    press_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("press_bounce_cols", {12'd0, cols}, m[0] ? 16'h000D : 16'h000F);
      chk("press_bounce_busy", {15'd0, busy}, 16'd1);
      m = lfsr_step(m);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      chk("bounce_hold_cols", {12'd0, cols}, 16'h000D);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      chk("release_bounce_cols", {12'd0, cols}, m[0] ? 16'h000D : 16'h000F);
      chk("release_bounce_done", {15'd0, done}, 16'd0);
      m = lfsr_step(m);
      tick();
    end
    chk("bounce_done", {15'd0, done}, 16'd1);
    chk("bounce_idle", {15'd0, busy}, 16'd0);
    chk("bounce_idle_cols", {12'd0, cols}, 16'h000F);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
